// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with integrated baud divider.
// Frame: start bit, DATA_BITS data bits LSB-first, optional parity, then 1 or 2 stop bits.
module uart_tx_param #(
    parameter int unsigned CLOCK_INPUT = 50_000_000,
    parameter int unsigned BAUDRATE    = 9600,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY      = 0,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 valid,
    input  logic [DATA_BITS-1:0] pdatain,
    output logic                 ready,
    output logic                 sdata,
    output logic                 busy
);

    localparam int unsigned DIV   = CLOCK_INPUT / BAUDRATE;
    localparam int unsigned CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic             ODD_MODE  = (PARITY == 1);
    localparam logic             HAS_PAR   = (PARITY != 0);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
    localparam logic [2:0] StParity = 3'd3;
    localparam logic [2:0] StStop   = 3'd4;

    if (PARITY > 2) begin : g_bad_parity
        $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_param: CLOCK_INPUT/BAUDRATE must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_tx_param: DATA_BITS must be in 5..9");
    end

    logic [2:0]           state_q, state_d;
    logic [CNT_W-1:0]     baud_q, baud_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic                 sdata_q, sdata_d;
    logic                 bit_end;

    assign bit_end = (baud_q == CNT_LAST);

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        unique case (state_q)
            StIdle: begin
                if (valid) begin
                    state_d  = StStart;
                    shift_d  = pdatain;
                    parity_d = (^pdatain) ^ ODD_MODE;
                    baud_d   = '0;
                    bit_d    = '0;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    baud_d  = '0;
                    bit_d   = '0;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            StData: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == LAST_DATA) begin
                        bit_d   = '0;
                        state_d = HAS_PAR ? StParity : StStop;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                    baud_d  = '0;
                    bit_d   = '0;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            StStop: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == LAST_STOP) begin
                        state_d = StIdle;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    // The line level is registered from the next state so sdata is glitch-free
    // and changes on the same edge as the state.
    always_comb begin
        sdata_d = 1'b1;
        unique case (state_d)
            StStart:  sdata_d = 1'b0;
            StData:   sdata_d = shift_d[0];
            StParity: sdata_d = parity_d;
            default:  sdata_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            sdata_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            sdata_q  <= sdata_d;
        end
    end

    assign ready = (state_q == StIdle);
    assign busy  = ~ready;
    assign sdata = sdata_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: five parameter sets sharing one clock, each frame
// checked cycle by cycle against a bit-list model built from the frame rules.
module tb_uart_tx_param;

    logic       clock = 1'b0;
    logic       rst [5];
    logic       vld [5];
    logic [8:0] din [5];
    logic       rdy [5];
    logic       sd  [5];
    logic       bsy [5];

    int div_c [5] = '{16, 16, 16, 3, 2};
    int dbits [5] = '{8, 8, 7, 8, 9};
    int par   [5] = '{0, 2, 0, 1, 2};
    int stops [5] = '{1, 1, 2, 1, 2};

    int n_vec = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    uart_tx_param #(.CLOCK_INPUT(16), .BAUDRATE(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
    dut_a (.clock(clock), .reset(rst[0]), .valid(vld[0]), .pdatain(din[0][7:0]),
           .ready(rdy[0]), .sdata(sd[0]), .busy(bsy[0]));

    uart_tx_param #(.CLOCK_INPUT(16), .BAUDRATE(1), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
    dut_b (.clock(clock), .reset(rst[1]), .valid(vld[1]), .pdatain(din[1][7:0]),
           .ready(rdy[1]), .sdata(sd[1]), .busy(bsy[1]));

    uart_tx_param #(.CLOCK_INPUT(16), .BAUDRATE(1), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2))
    dut_c (.clock(clock), .reset(rst[2]), .valid(vld[2]), .pdatain(din[2][6:0]),
           .ready(rdy[2]), .sdata(sd[2]), .busy(bsy[2]));

    uart_tx_param #(.CLOCK_INPUT(10), .BAUDRATE(3), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1))
    dut_d (.clock(clock), .reset(rst[3]), .valid(vld[3]), .pdatain(din[3][7:0]),
           .ready(rdy[3]), .sdata(sd[3]), .busy(bsy[3]));

    uart_tx_param #(.CLOCK_INPUT(5), .BAUDRATE(2), .DATA_BITS(9), .PARITY(2), .STOP_BITS(2))
    dut_e (.clock(clock), .reset(rst[4]), .valid(vld[4]), .pdatain(din[4][8:0]),
           .ready(rdy[4]), .sdata(sd[4]), .busy(bsy[4]));

    function automatic int frame_len(int idx);
        return div_c[idx] * (1 + dbits[idx] + ((par[idx] != 0) ? 1 : 0) + stops[idx]);
    endfunction

    // Line level of bit slot b of the frame carrying word w.
    function automatic logic exp_bit(int idx, logic [8:0] w, int b);
        int unsigned wi;
        int          ones;
        wi   = int'(w) & ((1 << dbits[idx]) - 1);
        ones = $countones(wi);
        if (b == 0) return 1'b0;
        if (b <= dbits[idx]) return 1'((wi >> (b - 1)) & 1);
        if (par[idx] != 0 && b == dbits[idx] + 1)
            return (par[idx] == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
        return 1'b1;
    endfunction

    // Called at the negedge just before the accept edge; checks every cycle of the frame
    // and the ready cycle that follows. Inputs are scrambled while busy.
    task automatic check_frame(int idx, logic [8:0] word, logic next_valid,
                               logic [8:0] next_word);
        int   len;
        int   bad;
        int   first;
        logic got_s, got_r, got_b, want_s;
        len   = frame_len(idx);
        bad   = 0;
        first = -1;
        want_s = 1'b1;
        got_s = 1'b0; got_r = 1'b0; got_b = 1'b0;
        for (int k = 0; k < len; k++) begin
            @(negedge clock);
            if (sd[idx] !== exp_bit(idx, word, k / div_c[idx]) || rdy[idx] !== 1'b0 ||
                bsy[idx] !== 1'b1) begin
                if (first < 0) begin
                    first  = k;
                    got_s  = sd[idx];
                    got_r  = rdy[idx];
                    got_b  = bsy[idx];
                    want_s = exp_bit(idx, word, k / div_c[idx]);
                end
                bad++;
            end
            if (k < len - 1) begin
                vld[idx] = 1'($urandom);
                din[idx] = 9'($urandom);
            end else begin
                vld[idx] = next_valid;
                din[idx] = next_word;
            end
        end
        n_vec++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL frame_line dut%0d word=%h: %0d bad cycles, first at %0d got sdata=%b ready=%b busy=%b want sdata=%b ready=0 busy=1",
                     idx, word, bad, first, got_s, got_r, got_b, want_s);
        end
        @(negedge clock);
        n_vec++;
        if (rdy[idx] !== 1'b1 || sd[idx] !== 1'b1 || bsy[idx] !== 1'b0) begin
            n_bad++;
            $display("FAIL ready_return dut%0d word=%h: got ready=%b sdata=%b busy=%b want 1 1 0",
                     idx, word, rdy[idx], sd[idx], bsy[idx]);
        end
    endtask

    task automatic check_idle(int idx, int cycles);
        int bad;
        bad = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clock);
            if (sd[idx] !== 1'b1 || rdy[idx] !== 1'b1 || bsy[idx] !== 1'b0) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL idle_line dut%0d: %0d of %0d cycles not idle, want sdata=1 ready=1 busy=0",
                     idx, bad, cycles);
        end
    endtask

    task automatic send(int idx, logic [8:0] word, logic next_valid, logic [8:0] next_word);
        int t;
        t = 0;
        while (rdy[idx] !== 1'b1 && t < 500) begin
            @(negedge clock);
            t++;
        end
        n_vec++;
        if (rdy[idx] !== 1'b1) begin
            n_bad++;
            $display("FAIL wait_ready dut%0d: got ready=%b want 1 within 500 cycles",
                     idx, rdy[idx]);
        end
        vld[idx] = 1'b1;
        din[idx] = word;
        check_frame(idx, word, next_valid, next_word);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            rst[i] = 1'b1;
            vld[i] = 1'b0;
            din[i] = '0;
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (sd[i] !== 1'b1 || rdy[i] !== 1'b1 || bsy[i] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_state dut%0d: got sdata=%b ready=%b busy=%b want 1 1 0",
                         i, sd[i], rdy[i], bsy[i]);
            end
            rst[i] = 1'b0;
        end
    endtask

    task automatic test_fixed_words();
        send(0, 9'h05A, 1'b0, 9'h0);
        send(1, 9'h05A, 1'b0, 9'h0);
        send(3, 9'h05A, 1'b0, 9'h0);
        send(2, 9'h07F, 1'b0, 9'h0);
        send(4, 9'h1A5, 1'b0, 9'h0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 5; i++) begin
                int gap;
                gap = $urandom_range(1, 4);
                check_idle(i, gap);
                send(i, 9'($urandom), 1'b0, 9'h0);
            end
        end
    endtask

    // Second start follows one ready cycle after the last stop cycle.
    task automatic test_back_to_back();
        send(0, 9'h0A5, 1'b1, 9'h03C);
        check_frame(0, 9'h03C, 1'b0, 9'h0);
        check_idle(0, 40);
    endtask

    task automatic test_reset_mid_frame();
        @(negedge clock);
        vld[0] = 1'b1;
        din[0] = 9'h0FF;
        @(negedge clock);
        vld[0] = 1'b0;
        repeat (71) @(negedge clock);
        rst[0] = 1'b1;
        @(negedge clock);
        n_vec++;
        if (sd[0] !== 1'b1 || rdy[0] !== 1'b1 || bsy[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_abort dut0: got sdata=%b ready=%b busy=%b want 1 1 0",
                     sd[0], rdy[0], bsy[0]);
        end
        rst[0] = 1'b0;
        check_idle(0, 48);
        send(0, 9'h000, 1'b0, 9'h0);
    endtask

    task automatic test_reset_with_valid();
        @(negedge clock);
        vld[4] = 1'b1;
        din[4] = 9'h155;
        repeat (7) @(negedge clock);
        rst[4] = 1'b1;
        vld[4] = 1'b1;
        din[4] = 9'h0C3;
        @(negedge clock);
        n_vec++;
        if (sd[4] !== 1'b1 || rdy[4] !== 1'b1 || bsy[4] !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_valid dut4: got sdata=%b ready=%b busy=%b want 1 1 0",
                     sd[4], rdy[4], bsy[4]);
        end
        rst[4] = 1'b0;
        check_frame(4, 9'h0C3, 1'b0, 9'h0);
        check_idle(4, 10);
    endtask

    initial begin
        test_reset();
        test_fixed_words();
        test_back_to_back();
        test_reset_mid_frame();
        test_reset_with_valid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
